// File: rtl/eco32_eth_pkg.sv
// Shared constants, ring-bus header layout and RX packet-former state encoding
// for the eco32 ethernet device box.
package eco32_eth_pkg;

   localparam logic [7:0] ETH_OP_WR           = 8'h81;
   localparam logic [7:0] CMD_ADD_RX_BUFF_PTR = 8'h01;
   localparam logic [7:0] CMD_ADD_TX_BUFF_PTR = 8'h02;
   localparam logic [7:0] CMD_GET_STATUS      = 8'h03;

   localparam int HDR_OP_LSB   = 64;
   localparam int HDR_NW_LSB   = 36;
   localparam int HDR_ADDR_LSB = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_FLUSH_HDR,
      ST_FLUSH_DATA,
      ST_DROP,
      ST_EVENT
   } rx_state_e;

   function automatic logic [71:0] mk_hdr(input logic [2:0] last_word, input logic [35:0] addr);
      logic [71:0] h;
      h = '0;
      h[HDR_OP_LSB +: 8]    = ETH_OP_WR;
      h[HDR_NW_LSB +: 4]    = {1'b0, last_word};
      h[HDR_ADDR_LSB +: 36] = addr;
      return h;
   endfunction

endpackage

// File: rtl/eco32_eth_rx_packer.sv
// 64-byte line buffer: byte-lane writes with enables, one 64-bit word read port,
// and the index of the highest word holding at least one byte.
module eco32_eth_rx_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_clr,
   input  logic        i_wr,
   input  logic [5:0]  i_pos,
   input  logic [7:0]  i_byte,
   input  logic [2:0]  i_rd_word,
   output logic [63:0] o_rd_data,
   output logic [7:0]  o_rd_be,
   output logic [2:0]  o_last_word
);
   logic [7:0][7:0][7:0] r_data;
   logic [7:0][7:0]      r_be;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_data <= '0;
         r_be   <= '0;
      end else if (i_wr) begin
         r_data[i_pos[5:3]][i_pos[2:0]] <= i_byte;
         r_be[i_pos[5:3]][i_pos[2:0]]   <= 1'b1;
      end
   end

   assign o_rd_data = r_data[i_rd_word];
   assign o_rd_be   = r_be[i_rd_word];

   always_comb begin
      o_last_word = '0;
      for (int i = 0; i < 8; i++)
         if (|r_be[i]) o_last_word = 3'(i);
   end
endmodule

// File: rtl/eco32_sfifo.sv
// Small synchronous FIFO; caller must not push when full or pop when empty.
module eco32_sfifo #(
   parameter int W     = 36,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0][W-1:0] r_mem;
   logic [AW-1:0]           r_wp, r_rp;
   logic [AW:0]             r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wp] <= i_data;
            r_wp        <= r_wp + 1'b1;
         end
         if (i_pop)
            r_rp <= r_rp + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_data  = r_mem[r_rp];
   assign o_full  = (r_cnt == (AW+1)'(DEPTH));
   assign o_empty = (r_cnt == '0);
endmodule

// File: rtl/eco32_ethernet_rx_pktform.sv
// RX packet former: packs received bytes into 64-byte lines, writes them to
// host RX buffers as ring-bus write packets and posts one completion per frame.
module eco32_ethernet_rx_pktform
   import eco32_eth_pkg::*;
#(
   parameter int PTR_FIFO_DEPTH = 4,
   parameter int MAX_LEN        = 1536
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_stb,
   input  logic [7:0]  i_data,
   input  logic        i_eof,
   input  logic        i_err,
   output logic        i_ack,
   input  logic        ptr_stb,
   input  logic [35:0] ptr_data,
   output logic        ptr_ack,
   output logic        dl_stb,
   output logic        dl_sof,
   output logic [71:0] dl_data,
   input  logic [1:0]  dl_af,
   output logic        ev_stb,
   output logic [35:0] ev_ptr,
   output logic [15:0] ev_len,
   output logic        ev_err,
   output logic        ev_ovf,
   input  logic        ev_ack
);
   rx_state_e   r_state, w_nxt_state;
   logic [35:0] r_cur_ptr;
   logic [15:0] r_cnt;
   logic        r_last, r_err, r_ovf;
   logic [2:0]  r_word;
   logic        r_dl_stb, r_dl_sof, r_ev_stb;
   logic [71:0] r_dl_data;

   logic        w_fifo_full, w_fifo_empty, w_pop;
   logic [35:0] w_fifo_dout;
   logic        w_ack, w_wr, w_clr, w_dl_stb, w_dl_sof, w_ev_stb;
   logic [71:0] w_dl_data;
   logic [63:0] w_rd_data;
   logic [7:0]  w_rd_be;
   logic [2:0]  w_last_word;
   logic [15:0] w_cnt_m1;
   logic [35:0] w_hdr_addr;
   logic        w_unused;

   assign ptr_ack = ptr_stb && !w_fifo_full;

   eco32_sfifo #(.W(36), .DEPTH(PTR_FIFO_DEPTH)) u_ptr_fifo (
      .clk(clk), .rst(rst), .i_push(ptr_ack), .i_data(ptr_data), .i_pop(w_pop),
      .o_data(w_fifo_dout), .o_full(w_fifo_full), .o_empty(w_fifo_empty)
   );

   eco32_eth_rx_packer u_packer (
      .clk(clk), .rst(rst), .i_clr(w_clr), .i_wr(w_wr), .i_pos(r_cnt[5:0]), .i_byte(i_data),
      .i_rd_word(r_word), .o_rd_data(w_rd_data), .o_rd_be(w_rd_be), .o_last_word(w_last_word)
   );

   // r_cnt already counts the byte that closed the line, so the line index is (cnt-1)/64.
   assign w_cnt_m1   = r_cnt - 16'd1;
   assign w_hdr_addr = {r_cur_ptr[35:6], 6'b0} + {20'b0, w_cnt_m1[15:6], 6'b0};
   assign w_unused   = ^{dl_af[1], w_cnt_m1[5:0]};

   always_comb begin
      w_nxt_state = r_state;
      w_pop       = 1'b0;
      w_ack       = 1'b0;
      w_wr        = 1'b0;
      w_clr       = 1'b0;
      w_dl_stb    = 1'b0;
      w_dl_sof    = 1'b0;
      w_dl_data   = '0;
      w_ev_stb    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_clr = 1'b1;
            if (!w_fifo_empty) begin
               w_pop       = 1'b1;
               w_nxt_state = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            w_ack = i_stb;
            w_wr  = i_stb;
            if (i_stb && (i_eof || r_cnt[5:0] == 6'd63))
               w_nxt_state = ST_FLUSH_HDR;
         end
         ST_FLUSH_HDR: begin
            if (!dl_af[0]) begin
               w_dl_stb    = 1'b1;
               w_dl_sof    = 1'b1;
               w_dl_data   = mk_hdr(w_last_word, w_hdr_addr);
               w_nxt_state = ST_FLUSH_DATA;
            end
         end
         ST_FLUSH_DATA: begin
            w_dl_stb  = 1'b1;
            w_dl_data = {w_rd_be, w_rd_data};
            if (r_word == w_last_word) begin
               w_clr = 1'b1;
               if (r_last)
                  w_nxt_state = ST_EVENT;
               else if (r_cnt == 16'(MAX_LEN))
                  w_nxt_state = ST_DROP;
               else
                  w_nxt_state = ST_COLLECT;
            end
         end
         ST_DROP: begin
            w_ack = i_stb;
            if (i_stb && i_eof)
               w_nxt_state = ST_EVENT;
         end
         ST_EVENT: begin
            w_ev_stb = 1'b1;
            if (r_ev_stb && ev_ack) begin
               w_ev_stb    = 1'b0;
               w_nxt_state = ST_IDLE;
            end
         end
         default: w_nxt_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cur_ptr <= '0;
         r_cnt     <= '0;
         r_last    <= 1'b0;
         r_err     <= 1'b0;
         r_ovf     <= 1'b0;
         r_word    <= '0;
         r_dl_stb  <= 1'b0;
         r_dl_sof  <= 1'b0;
         r_dl_data <= '0;
         r_ev_stb  <= 1'b0;
      end else begin
         r_state   <= w_nxt_state;
         r_dl_stb  <= w_dl_stb;
         r_dl_sof  <= w_dl_sof;
         r_dl_data <= w_dl_data;
         r_ev_stb  <= w_ev_stb;
         if (w_pop) begin
            r_cur_ptr <= w_fifo_dout;
            r_cnt     <= '0;
            r_last    <= 1'b0;
            r_err     <= 1'b0;
            r_ovf     <= 1'b0;
         end
         if (w_wr)
            r_cnt <= r_cnt + 16'd1;
         if (r_state == ST_COLLECT && i_stb && i_eof) begin
            r_last <= 1'b1;
            r_err  <= i_err;
         end
         if (r_state == ST_DROP && i_stb && i_eof) begin
            r_err <= i_err;
            r_ovf <= 1'b1;
         end
         if (r_state == ST_FLUSH_HDR)
            r_word <= '0;
         else if (r_state == ST_FLUSH_DATA)
            r_word <= r_word + 3'd1;
      end
   end

   assign i_ack   = w_ack;
   assign dl_stb  = r_dl_stb;
   assign dl_sof  = r_dl_sof;
   assign dl_data = r_dl_data;
   assign ev_stb  = r_ev_stb;
   assign ev_ptr  = r_cur_ptr;
   assign ev_len  = r_cnt;
   assign ev_err  = r_err;
   assign ev_ovf  = r_ovf;
endmodule

// File: tb/tb_eco32_ethernet_rx_pktform.sv
// Bench for the RX packet former: random frames against a line-splitting
// reference model, plus directed back-pressure, overflow and reset cases.
module tb_eco32_ethernet_rx_pktform;
   import eco32_eth_pkg::*;

   localparam int MAX_LEN = 1536;

   logic        clk = 1'b0, rst = 1'b1;
   logic        i_stb = 1'b0, i_eof = 1'b0, i_err = 1'b0, i_ack;
   logic [7:0]  i_data = '0;
   logic        ptr_stb = 1'b0, ptr_ack;
   logic [35:0] ptr_data = '0;
   logic        dl_stb, dl_sof;
   logic [71:0] dl_data;
   logic [1:0]  dl_af = '0;
   logic        ev_stb, ev_err, ev_ovf;
   logic        ev_ack = 1'b0;
   logic [35:0] ev_ptr;
   logic [15:0] ev_len;

   eco32_ethernet_rx_pktform #(.PTR_FIFO_DEPTH(4), .MAX_LEN(MAX_LEN)) dut (
      .clk(clk), .rst(rst), .i_stb(i_stb), .i_data(i_data), .i_eof(i_eof), .i_err(i_err),
      .i_ack(i_ack), .ptr_stb(ptr_stb), .ptr_data(ptr_data), .ptr_ack(ptr_ack),
      .dl_stb(dl_stb), .dl_sof(dl_sof), .dl_data(dl_data), .dl_af(dl_af),
      .ev_stb(ev_stb), .ev_ptr(ev_ptr), .ev_len(ev_len), .ev_err(ev_err), .ev_ovf(ev_ovf),
      .ev_ack(ev_ack)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [72:0] q_dl[$], q_exp[$], last_dl[$];
   logic [53:0] q_ev[$], last_ev;
   int          dl_rd = 0, ev_rd = 0;
   int          af_mode = 0, rem = 0, mon_burst_bad = 0, mon_af_bad = 0;
   logic [7:0]  frm [0:2047];

   // Ring/event sink: records words, checks burst contiguity, drives dl_af and ev_ack.
   always @(negedge clk) begin
      if (rst) begin
         rem    = 0;
         ev_ack = 1'b0;
      end else begin
         if (rem > 0) begin
            if (dl_stb && !dl_sof) begin
               q_dl.push_back({1'b0, dl_data});
               rem--;
            end else begin
               mon_burst_bad++;
               rem = 0;
            end
         end else if (dl_stb) begin
            if (!dl_sof) mon_burst_bad++;
            if (dl_af[0]) mon_af_bad++;
            q_dl.push_back({1'b1, dl_data});
            rem = int'(dl_data[39:36]) + 1;
         end
         if (ev_ack)
            ev_ack = 1'b0;
         else if (ev_stb && $urandom_range(1) == 1) begin
            q_ev.push_back({ev_ptr, ev_len, ev_err, ev_ovf});
            ev_ack = 1'b1;
         end
      end
      case (af_mode)
         0:       dl_af = 2'b00;
         1:       dl_af = 2'($urandom_range(3));
         default: dl_af = 2'b01;
      endcase
   end

   task automatic push_ptr(input logic [35:0] p, output logic ack);
      @(negedge clk);
      ptr_stb  = 1'b1;
      ptr_data = p;
      #1 ack = ptr_ack;
      @(posedge clk);
      #1 ptr_stb = 1'b0;
   endtask

   task automatic send_frame(input int len, input logic err, input logic eof_en, output int acked);
      int tmo;
      acked = 0;
      for (int i = 0; i < len; i++) begin
         if ($urandom_range(3) == 0) begin
            @(negedge clk);
            i_stb = 1'b0;
         end
         @(negedge clk);
         i_stb  = 1'b1;
         i_data = frm[i];
         i_eof  = eof_en && (i == len - 1);
         i_err  = err && eof_en && (i == len - 1);
         #1 tmo = 0;
         while (!i_ack && tmo < 3000) begin
            @(negedge clk);
            #1 tmo++;
         end
         if (!i_ack) begin
            chk("byte_ack_timeout", 0, 1);
            break;
         end
         acked++;
      end
      @(negedge clk);
      i_stb = 1'b0;
      i_eof = 1'b0;
      i_err = 1'b0;
   endtask

   task automatic no_ptr_hold(input int n);
      logic any;
      any = 1'b0;
      @(negedge clk);
      i_stb  = 1'b1;
      i_data = frm[0];
      repeat (n) begin
         #1 any |= i_ack;
         @(negedge clk);
      end
      i_stb = 1'b0;
      chk("noptr_ack", any, 0);
   endtask

   // Reference: split the stored bytes into 64-byte lines, each a header plus
   // one word per 8-byte group that holds any byte.
   task automatic build_exp(input logic [35:0] ptr, input int len, input logic err, output logic [53:0] ev);
      int stored, nl, lb, nw, k;
      logic [7:0]  be;
      logic [63:0] d;
      logic [35:0] a;
      stored = (len > MAX_LEN) ? MAX_LEN : len;
      nl = (stored + 63) / 64;
      q_exp.delete();
      for (int li = 0; li < nl; li++) begin
         lb = stored - 64 * li;
         if (lb > 64) lb = 64;
         nw = (lb + 7) / 8;
         a  = {ptr[35:6], 6'b0} + 36'(64 * li);
         q_exp.push_back({1'b1, ETH_OP_WR, 24'h0, 4'(nw - 1), a});
         for (int w = 0; w < nw; w++) begin
            be = '0;
            d  = '0;
            for (int b = 0; b < 8; b++) begin
               k = 64 * li + 8 * w + b;
               if (k < stored) begin
                  be[b]       = 1'b1;
                  d[8*b +: 8] = frm[k];
               end
            end
            q_exp.push_back({1'b0, be, d});
         end
      end
      ev = {ptr, 16'(stored), err, (len > MAX_LEN)};
   endtask

   task automatic check_frame(input logic [35:0] ptr, input int len, input logic err);
      logic [53:0] eexp;
      int tmo, n;
      build_exp(ptr, len, err, eexp);
      tmo = 0;
      while (q_ev.size() <= ev_rd && tmo < 5000) begin
         @(negedge clk);
         tmo++;
      end
      if (q_ev.size() <= ev_rd) begin
         chk("event_timeout", 0, 1);
         last_ev = '0;
      end else begin
         last_ev = q_ev[ev_rd];
         ev_rd++;
         chk("event", last_ev, eexp);
      end
      n = q_dl.size() - dl_rd;
      chk("dl_word_count", n, q_exp.size());
      last_dl.delete();
      for (int i = 0; i < n; i++) begin
         last_dl.push_back(q_dl[dl_rd + i]);
         if (i < q_exp.size()) chk($sformatf("dl_word%0d", i), q_dl[dl_rd + i], q_exp[i]);
      end
      dl_rd += n;
      chk("burst_contiguous", mon_burst_bad, 0);
      chk("hdr_af_clear", mon_af_bad, 0);
   endtask

   task automatic run_frame(input logic [35:0] p, input int len, input logic err);
      logic a;
      int acked;
      push_ptr(p, a);
      chk("ptr_ack", a, 1);
      send_frame(len, err, 1'b1, acked);
      chk("bytes_acked", acked, len);
      check_frame(p, len, err);
   endtask

   initial begin
      logic        a;
      int          acked, len, nh;
      logic [35:0] p;

      repeat (3) @(negedge clk);
      i_stb = 1'b1;
      #1;
      chk("rst_dl_stb", dl_stb, 0);
      chk("rst_ev_stb", ev_stb, 0);
      chk("rst_dl_data", dl_data, 0);
      chk("rst_i_ack", i_ack, 0);
      @(negedge clk);
      i_stb = 1'b0;
      rst   = 1'b0;

      // 64-byte incrementing frame
      for (int i = 0; i < 64; i++) frm[i] = 8'(i);
      run_frame(36'h0_0001_0000, 64, 1'b0);
      chk("t1_hdr", last_dl[0], {1'b1, ETH_OP_WR, 24'h0, 4'd7, 36'h0_0001_0000});
      chk("t1_word0", last_dl[1], {1'b0, 8'hFF, 64'h0706050403020100});
      chk("t1_event", last_ev, {36'h0_0001_0000, 16'd64, 1'b0, 1'b0});

      // 70-byte frame: second line carries 6 bytes
      for (int i = 0; i < 70; i++) frm[i] = 8'($urandom);
      run_frame(36'h0_0001_0000, 70, 1'b0);
      chk("t2_hdr2", last_dl[9], {1'b1, ETH_OP_WR, 24'h0, 4'd0, 36'h0_0001_0040});
      chk("t2_be", last_dl[10][71:64], 8'h3F);
      chk("t2_len", last_ev[17:2], 16'd70);

      // frame waits for a pointer
      for (int i = 0; i < 100; i++) frm[i] = 8'($urandom);
      no_ptr_hold(20);
      run_frame(36'h3_0000_1000, 100, 1'b0);

      // dl_af held on a full line, then released and toggled
      af_mode = 2;
      for (int i = 0; i < 64; i++) frm[i] = 8'($urandom);
      push_ptr(36'h0_0020_0000, a);
      send_frame(64, 1'b0, 1'b1, acked);
      repeat (10) @(negedge clk);
      chk("af_hold_no_stb", q_dl.size() - dl_rd, 0);
      af_mode = 1;
      check_frame(36'h0_0020_0000, 64, 1'b0);
      af_mode = 0;

      // oversize frame with error
      for (int i = 0; i < 1600; i++) frm[i] = 8'($urandom);
      run_frame(36'h0_0100_0000, 1600, 1'b1);
      nh = 0;
      foreach (last_dl[i]) if (last_dl[i][72]) nh++;
      chk("t5_lines", nh, 24);
      chk("t5_event", last_ev[17:0], {16'd1536, 1'b1, 1'b1});

      // random frames
      for (int f = 0; f < 12; f++) begin
         case ($urandom_range(5))
            0:       len = $urandom_range(8, 1);
            1:       len = $urandom_range(70, 60);
            2:       len = $urandom_range(MAX_LEN, 1);
            3:       len = $urandom_range(1700, 1530);
            4:       len = 64 * $urandom_range(24, 1);
            default: len = MAX_LEN + $urandom_range(1);
         endcase
         p = {4'($urandom), $urandom};
         for (int i = 0; i < len; i++) frm[i] = 8'($urandom);
         af_mode = $urandom_range(1);
         run_frame(p, len, 1'($urandom));
      end
      af_mode = 0;

      // FIFO full, then reset mid-line
      push_ptr(36'h0_0300_0000, a);
      chk("fifo_first", a, 1);
      repeat (3) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         push_ptr(36'h0_0400_0000 + 36'(64 * k), a);
         chk($sformatf("fifo_ack%0d", k), a, (k < 4));
      end
      for (int i = 0; i < 30; i++) frm[i] = 8'($urandom);
      send_frame(30, 1'b0, 1'b0, acked);
      chk("partial_acked", acked, 30);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      chk("rst_no_dl", q_dl.size() - dl_rd, 0);
      chk("rst_no_ev", q_ev.size() - ev_rd, 0);
      no_ptr_hold(20);

      for (int i = 0; i < 65; i++) frm[i] = 8'($urandom);
      run_frame(36'h0_0500_0000, 65, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/eco32_ethernet_rx_pktform.md
Name: eco32_ethernet_rx_pktform

Overview:
- Receive-path stage feeding the downlink side of the ethernet device box.
- Accepts the received-frame byte stream from the MAC receiver and packs it into 64-byte lines.
- Writes each line to a host-supplied RX buffer as ring-bus write packets (dl_stb/dl_sof/dl_data/dl_af).
- Reports each completed frame through a single-entry completion event that the box turns into a dl_eve.

Parameters:
- PTR_FIFO_DEPTH, 4: number of queued RX buffer pointers; power of two.
- MAX_LEN, 1536: RX buffer size in bytes; multiple of 64; bytes beyond it are dropped.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset (box drives rst||soft_rst)
- i_stb  in  1  byte valid from MAC receiver
- i_data  in  8  received byte
- i_eof  in  1  qualifies i_stb: last byte of frame
- i_err  in  1  qualifies i_eof: CRC/PHY error on frame
- i_ack  out  1  byte consumed this cycle
- ptr_stb  in  1  new RX buffer pointer (from CMD_ADD_RX_BUFF_PTR decode)
- ptr_data  in  36  buffer byte address; bits [5:0] ignored
- ptr_ack  out  1  pointer accepted (=ptr_stb && !fifo_full)
- dl_stb  out  1  ring word valid
- dl_sof  out  1  first (header) word of packet
- dl_data  out  72  ring word
- dl_af  in  2  ring almost-full; bit 0 gates packet start
- ev_stb  out  1  frame-done event valid
- ev_ptr  out  36  buffer pointer of completed frame
- ev_len  out  16  stored byte count
- ev_err  out  1  frame carried i_err
- ev_ovf  out  1  frame exceeded MAX_LEN
- ev_ack  in  1  event consumed

Behaviour:
- Reset is synchronous: all outputs 0, FSM to IDLE, pointer FIFO empty, byte counter 0.
- Reset mid-frame discards the partial line and all queued pointers; no event is issued.
- Pointer FIFO:
  - ptr_stb && full: pointer is refused (ptr_ack=0).
  - A push and a pop in the same cycle are both legal.
- FSM state IDLE: wait for a non-empty FIFO; pop it into cur_ptr; cnt:=0; go to COLLECT. i_ack=0.
- FSM state COLLECT: i_ack = i_stb && line not full.
  - The accepted byte goes to lane cnt[2:0] of word cnt[5:3]; its byte-enable bit is set; cnt++.
  - The byte that fills the line (cnt[5:0] wraps to 0) goes to FLUSH_HDR.
  - i_eof goes to FLUSH_HDR with the last-flag set. If it coincides with the line filling, only one flush occurs.
  - When cnt==MAX_LEN and no eof has arrived, go to DROP.
- FSM state FLUSH_HDR: wait until dl_af[0]==0, then drive one header word with dl_sof=1.
  - [71:64] = ETH_OP_WR.
  - [63:40] = 0.
  - [39:36] = data words - 1 (0..7; partial last line counts only words holding >=1 byte).
  - [35:0] = cur_ptr[35:6]*64 + line_index*64.
- FSM state FLUSH_DATA: one word per cycle, contiguous, dl_sof=0; dl_af is ignored once started.
  - [71:64] = byte-enable.
  - [63:0] = data, lane 0 in [7:0].
  - After the last word: if last-flag is set go to EVENT, else clear the line and return to COLLECT.
- FSM state DROP: i_ack = i_stb; bytes are discarded until i_eof, then EVENT with ev_ovf=1.
- FSM state EVENT: hold ev_stb with ev_ptr=cur_ptr, ev_len=bytes stored (<=MAX_LEN), ev_err, ev_ovf until ev_ack; then go to IDLE.
- Outputs are registered.
- Latency: line-filling byte -> header word = 1 cycle (dl_af clear); 8 data words follow back-to-back.
- i_err is honoured only with i_eof. The data is written anyway; the host discards it via ev_err.
- i_err on a dropped frame reports both ev_err=1 and ev_ovf=1.
- No pointer available: i_ack stays 0 and the upstream MAC holds or drops per its own policy.

Decomposition:
- Package eco32_eth_pkg:
  - ETH_OP_WR.
  - CMD_ADD_RX_BUFF_PTR=8'h01, CMD_ADD_TX_BUFF_PTR=8'h02, CMD_GET_STATUS=8'h03.
  - FSM state enum; header field offsets.
- Sub-module eco32_eth_rx_packer: 8x64-bit line buffer with byte enables, lane write, word read port, word-count output.
- Pointer FIFO uses the codebase's standard small FIFO.

Test Plan:
- Push ptr 0x0_0001_0000; send a 64-byte frame 0x00..0x3F with eof on the last byte:
  - header addr 0x000010000, len field 7, 8 data words, word0 data 0x0706050403020100, BE 0xFF.
  - Event ptr 0x000010000, len 64, err=0, ovf=0.
- Send a 70-byte frame: second packet addr 0x000010040, len field 0, data word BE 0x3F; event len 70.
- No pointer queued, frame presented: i_ack stays 0 for 20 cycles. Push the pointer; the frame then completes normally.
- Hold dl_af[0]=1 when a line fills: no dl_stb until released, then header plus 8 words contiguous. Toggling dl_af mid-burst does not stall the burst.
- Send a 1600-byte frame with i_err on eof: 24 lines written; event len 1536, ovf=1, err=1; all 1600 bytes acked.
- Push 5 pointers: the 5th gets ptr_ack=0. Assert rst mid-line: no further dl_stb or ev_stb; FIFO empty afterwards.
